// File: rtl/code_pkg.sv
// Shared types for the code entry stage: FSM state encoding and code width.
package code_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/code_entry_ctrl_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs; reset clears both stages.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/code_entry_ctrl.sv
// Debounced pushbutton capture of a 4-bit switch code for the Display encoder.
// The code is latched only on a confirmed press and held stable between presses.
module code_entry_ctrl
  import code_pkg::*;
#(
  parameter int  DEB_CYCLES = 16,
  localparam int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       btn,
  input  logic       clr,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       ready,
  output logic       cap_pulse,
  output logic [3:0] entry_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic              btn_s;
  logic [CODE_W-1:0] sw_s;

  sync2 #(.WIDTH(1)) u_btn_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (btn),
    .q     (btn_s)
  );

  sync2 #(.WIDTH(CODE_W)) u_sw_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (sw),
    .q     (sw_s)
  );

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              capture;
  logic [CODE_W-1:0] code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter tracks how many consecutive samples agree with the pending level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = DEB_PRESS;
          cnt_nxt   = CNT_W'(1);
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = DEB_RELEASE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      DEB_RELEASE: begin
        if (btn_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Capture outranks clr so a collision still presents the fresh code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code      <= '0;
      ready     <= 1'b0;
      cap_pulse <= 1'b0;
      entry_cnt <= '0;
    end else begin
      cap_pulse <= capture;
      if (capture) begin
        code      <= sw_s;
        ready     <= 1'b1;
        entry_cnt <= entry_cnt + 4'd1;
      end else if (clr) begin
        ready <= 1'b0;
      end
    end
  end

  assign a = code[3];
  assign b = code[2];
  assign c = code[1];
  assign d = code[0];

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Scoreboard bench for code_entry_ctrl with a short debounce window.
module tb_code_entry_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       btn;
  logic       clr;
  logic       a, b, c, d;
  logic       ready;
  logic       cap_pulse;
  logic [3:0] entry_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_caps   = 0;
  int         caps0;
  logic [7:0] sb[$];
  logic [7:0] item;
  logic [3:0] exp_cnt;
  logic       prev_pulse = 1'b0;

  code_entry_ctrl #(.DEB_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn       (btn),
    .clr       (clr),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .ready     (ready),
    .cap_pulse (cap_pulse),
    .entry_cnt (entry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every capture strobe is matched against the oldest expected capture.
  always @(negedge clk) begin
    if (cap_pulse === 1'b1) begin
      n_caps++;
      check("cap_not_back_to_back", {31'd0, prev_pulse}, 0);
      if (sb.size() == 0) begin
        check("unexpected_capture", sb.size(), 1);
      end else begin
        item = sb.pop_front();
        check("cap_code", {28'd0, a, b, c, d}, {28'd0, item[7:4]});
        check("cap_entry_cnt", {28'd0, entry_cnt}, {28'd0, item[3:0]});
        check("cap_ready", {31'd0, ready}, 1);
      end
    end
    prev_pulse = cap_pulse;
  end

  task automatic do_reset();
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    reset = 1'b0;
    btn   = 1'b0;
    clr   = 1'b0;
    sb.delete();
    exp_cnt = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic press(input logic [3:0] val, input int hold, input int low, input bit expect_cap);
    @(negedge clk);
    sw  = val;
    btn = 1'b1;
    if (expect_cap) begin
      exp_cnt = exp_cnt + 4'd1;
      sb.push_back({val, exp_cnt});
    end
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    btn   = 1'b1;
    sw    = 4'b1111;
    clr   = 1'b0;
    #1 reset = 1'b0;

    // Reset with the button held: a fresh debounce after release.
    repeat (3) begin
      @(negedge clk);
      check("rst_outputs_zero", {20'd0, a, b, c, d, ready, cap_pulse, entry_cnt, 2'b00}, 0);
    end
    reset   = 1'b1;
    exp_cnt = 4'd1;
    sb.push_back({4'b1111, 4'd1});
    repeat (5) @(posedge clk);
    #1 check("rst_lat_no_early_cap", {31'd0, cap_pulse}, 0);
    @(posedge clk);
    #1 check("rst_lat_cap_edge6", {31'd0, cap_pulse}, 1);
    check("rst_cap_code", {28'd0, a, b, c, d}, 32'hF);
    check("rst_cap_cnt", {28'd0, entry_cnt}, 1);
    @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);

    // Clean press.
    do_reset();
    caps0 = n_caps;
    press(4'b0001, 20, 20, 1'b1);
    check("clean_code", {28'd0, a, b, c, d}, 32'h1);
    check("clean_ready", {31'd0, ready}, 1);
    check("clean_cnt", {28'd0, entry_cnt}, 1);
    check("clean_caps", n_caps - caps0, 1);

    // Bounce shorter than the debounce window.
    do_reset();
    caps0 = n_caps;
    @(negedge clk);
    sw  = 4'b0101;
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    check("bounce_caps", n_caps - caps0, 0);
    check("bounce_ready", {31'd0, ready}, 0);
    check("bounce_cnt", {28'd0, entry_cnt}, 0);

    // Switches move while the button is held.
    do_reset();
    caps0 = n_caps;
    @(negedge clk);
    sw      = 4'b0110;
    btn     = 1'b1;
    exp_cnt = 4'd1;
    sb.push_back({4'b0110, 4'd1});
    repeat (10) @(negedge clk);
    sw = 4'b1010;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    check("iso_code", {28'd0, a, b, c, d}, 32'h6);
    check("iso_caps", n_caps - caps0, 1);

    // clr coincident with the capture, then clr alone.
    do_reset();
    caps0 = n_caps;
    @(negedge clk);
    sw      = 4'b1101;
    btn     = 1'b1;
    exp_cnt = 4'd1;
    sb.push_back({4'b1101, 4'd1});
    repeat (5) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 check("collide_pulse", {31'd0, cap_pulse}, 1);
    check("collide_ready", {31'd0, ready}, 1);
    check("collide_code", {28'd0, a, b, c, d}, 32'hD);
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_clr_ready", {31'd0, ready}, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_ready", {31'd0, ready}, 0);
    check("clr_code_kept", {28'd0, a, b, c, d}, 32'hD);
    check("clr_cnt_kept", {28'd0, entry_cnt}, 1);
    check("clr_caps", n_caps - caps0, 1);

    // entry_cnt wrap, then reset in the middle of a press debounce.
    do_reset();
    caps0 = n_caps;
    for (int i = 0; i < 17; i++) begin
      press(4'(i * 3 + 1), 10, 10, 1'b1);
    end
    check("wrap_cnt", {28'd0, entry_cnt}, 1);
    check("wrap_caps", n_caps - caps0, 17);
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("midreset_cnt", {28'd0, entry_cnt}, 0);
    check("midreset_ready", {31'd0, ready}, 0);
    check("midreset_code", {28'd0, a, b, c, d}, 0);
    btn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
